image_capture_packer: RTL

IMAGE_CAPTURE_PACKER -- requirements
Module: image_capture_packer

---
 rtl/image_capture_packer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/image_capture_packer.sv
// Captures one image frame from the sensor model and packs three 9-bit pixels
// per 32-bit SRAM word, flushing a zero-filled partial word at end of frame.
module image_capture_packer #(
    parameter int          FRAME_PIXELS    = 512,
    parameter logic [14:0] BASE_ADDR       = 15'h0000,
    parameter int          CAPTURE_LATENCY = 1
) (
    input  logic        in_HCLK,
    input  logic        in_HRESET,
    input  logic        in_start,
    input  logic [8:0]  in_ISM_data_read,
    input  logic        in_ISM_done,
    output logic        out_ISM_frame_capture,
    output logic        out_SRAM_we,
    output logic [14:0] out_SRAM_w_ADDR,
    output logic [31:0] out_SRAM_w_DATA,
    output logic        out_busy,
    output logic        out_done,
    output logic        out_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_WAIT, S_STREAM, S_FLUSH, S_DONE
    } state_t;

    localparam logic [9:0] LAST_PIX  = 10'(FRAME_PIXELS - 1);
    localparam logic [3:0] WAIT_LAST = 4'(CAPTURE_LATENCY - 2);

    state_t      state_q, state_d;
    logic [9:0]  pix_cnt_q, pix_cnt_d;
    logic [1:0]  slot_q, slot_d;
    logic [14:0] word_q, word_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic [17:0] pack_q, pack_d;
    logic        cap_q, cap_d;
    logic        we_q, we_d;
    logic [14:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [26:0] word_v;
    logic        last_pix;
    logic        finish;

    // Word as it looks once the current pixel lands in its slot; unused upper
    // slots stay zero so a partial word is already zero-filled.
    always_comb begin
        case (slot_q)
            2'd0:    word_v = {18'b0, in_ISM_data_read};
            2'd1:    word_v = {9'b0, in_ISM_data_read, pack_q[8:0]};
            default: word_v = {in_ISM_data_read, pack_q};
        endcase
    end

    assign last_pix = (pix_cnt_q == LAST_PIX);
    assign finish   = last_pix || in_ISM_done;

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        slot_d    = slot_q;
        word_d    = word_q;
        lat_cnt_d = lat_cnt_q;
        pack_d    = pack_q;
        cap_d     = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    state_d   = S_CAPTURE;
                    cap_d     = 1'b1;
                    busy_d    = 1'b1;
                    error_d   = 1'b0;
                    pix_cnt_d = '0;
                    slot_d    = '0;
                    word_d    = BASE_ADDR;
                    lat_cnt_d = '0;
                    pack_d    = '0;
                end
            end
            S_CAPTURE: begin
                lat_cnt_d = '0;
                state_d   = (CAPTURE_LATENCY == 1) ? S_STREAM : S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt_q == WAIT_LAST) begin
                    state_d = S_STREAM;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            S_STREAM: begin
                pix_cnt_d = pix_cnt_q + 10'd1;
                // A full word, or whatever is pending at end of frame, is
                // registered here so the write shows up the following cycle.
                if (slot_q == 2'd2 || finish) begin
                    we_d   = 1'b1;
                    addr_d = word_q;
                    data_d = {5'b0, word_v};
                    word_d = word_q + 15'd1;
                    pack_d = '0;
                    slot_d = '0;
                end else begin
                    pack_d = word_v[17:0];
                    slot_d = slot_q + 2'd1;
                end
                if (finish) begin
                    state_d = S_FLUSH;
                    if (in_ISM_done != last_pix) begin
                        error_d = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge in_HCLK or negedge in_HRESET) begin
        if (!in_HRESET) begin
            state_q   <= S_IDLE;
            pix_cnt_q <= '0;
            slot_q    <= '0;
            word_q    <= '0;
            lat_cnt_q <= '0;
            pack_q    <= '0;
            cap_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            slot_q    <= slot_d;
            word_q    <= word_d;
            lat_cnt_q <= lat_cnt_d;
            pack_q    <= pack_d;
            cap_q     <= cap_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign out_ISM_frame_capture = cap_q;
    assign out_SRAM_we           = we_q;
    assign out_SRAM_w_ADDR       = addr_q;
    assign out_SRAM_w_DATA       = data_q;
    assign out_busy              = busy_q;
    assign out_done              = done_q;
    assign out_error             = error_q;

endmodule
